// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: default widths and LC-3 NZP condition-code encodings.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef logic [2:0] nzp_t;

  localparam nzp_t CC_N    = 3'b100;
  localparam nzp_t CC_Z    = 3'b010;
  localparam nzp_t CC_P    = 3'b001;
  localparam nzp_t NZP_RST = CC_Z;

endpackage

// File: rtl/cc_gen.sv
// Combinational NZP generator: classifies a data word as negative, zero or positive.
module cc_gen #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [2:0]        o_nzp
);
  import cpu_pkg::*;

  always_comb begin
    o_nzp = CC_P;
    if (i_data[DATA_W-1])   o_nzp = CC_N;
    else if (i_data == '0)  o_nzp = CC_Z;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with 2 read ports, 1 write port, optional write-to-read bypass,
// per-register busy scoreboard and NZP condition-code register.
module regfile_sb #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W_DEF,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cc_we,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dr,
  output logic [2:0]        nzp,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  import cpu_pkg::*;

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [2:0]          r_nzp;

  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [2:0]          w_cc_nzp;
  logic                w_fwd1;
  logic                w_fwd2;

  cc_gen #(.DATA_W(DATA_W)) u_cc_gen (
    .i_data (wdata),
    .o_nzp  (w_cc_nzp)
  );

  // Issue is applied after the writeback clear so a same-edge issue wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we)        w_busy_nxt[waddr]  = 1'b0;
    if (iss_valid) w_busy_nxt[iss_dr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_busy <= '0;
      r_nzp  <= NZP_RST;
    end else begin
      if (we) begin
        r_mem[waddr] <= wdata;
        if (cc_we) r_nzp <= w_cc_nzp;
      end
      r_busy <= w_busy_nxt;
    end
  end

  // Forwarding is suppressed in reset so the read ports show the cleared state.
  always_comb begin
    w_fwd1 = BYPASS && rst_n && we && (waddr == ra1);
    w_fwd2 = BYPASS && rst_n && we && (waddr == ra2);
  end

  always_comb begin
    rd1      = w_fwd1 ? wdata : r_mem[ra1];
    rd2      = w_fwd2 ? wdata : r_mem[ra2];
    busy1    = r_busy[ra1] & ~w_fwd1;
    busy2    = r_busy[ra2] & ~w_fwd2;
    nzp      = r_nzp;
    dbg_data = r_mem[dbg_addr];
  end

endmodule
